hex_ascii_streamer: RTL and testbench

Parametrised successor of the combinational hex-to-ASCII decoder used on the LCD path. It captures a DATA_W-bit value (CRC or any status word) with a valid/ready handshake and holds a registered parallel ASCII string for direct display. It also streams the same hex characters one per handshake, MSB nibble first, to the LCD character writer. Case selection and leading-zero suppression are added as options.

---
 rtl/hex_ascii_streamer_if.sv | 17 +
 rtl/hex_ascii_streamer.sv | 126 ++++++++++++
 tb/tb_hex_ascii_streamer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/hex_ascii_streamer_if.sv
// hex_ascii_streamer_if: capture handshake, parallel ASCII string and character stream
// of hex_ascii_streamer; master is the upstream/LCD side, slave is the converter.
interface hex_ascii_streamer_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0]   in_data;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W*2-1:0] str_out;
    logic [7:0]          ch_data;
    logic                ch_valid;
    logic                ch_ready;
    logic                ch_last;
    logic                busy;
    modport master (output in_data, in_valid, ch_ready,
                    input in_ready, str_out, ch_data, ch_valid, ch_last, busy);
    modport slave (input in_data, in_valid, ch_ready,
                   output in_ready, str_out, ch_data, ch_valid, ch_last, busy);
endinterface

// File: rtl/hex_ascii_streamer.sv
// hex_ascii_streamer: captures a DATA_W value, holds its ASCII hex string and streams the
// digits MSB first; HEX_PREFIX_EN adds a leading "0x" to the stream only.
module hex_ascii_streamer #(
    parameter int DATA_W      = 32,
    parameter int UPPER_CASE  = 1,
    parameter int SUPPRESS_LZ = 0
) (
    input logic                 clk,
    input logic                 rst,
    hex_ascii_streamer_if.slave bus
);
    localparam int N  = DATA_W / 4;
    localparam int IW = N > 1 ? $clog2(N) : 1;

`ifdef HEX_PREFIX_EN
    typedef enum logic [1:0] {IDLE, PRE0, PREX, SEND} state_t;
`else
    typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif

    state_t              state, state_n;
    logic [DATA_W-1:0]   data, data_n;
    logic [IW-1:0]       idx, idx_n, start;
    logic [DATA_W*2-1:0] str, str_n;
    logic [7:0]          chd, chd_n;
    logic                chv, chv_n, chl, chl_n;
    logic [IW-1:0]       idx_dn;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + 8'(n) : (UPPER_CASE != 0 ? 8'h37 : 8'h57) + 8'(n);
    endfunction

    function automatic logic [3:0] nib(input logic [DATA_W-1:0] v, input int i);
        logic [DATA_W-1:0] t;
        t = v >> (4 * i);
        return t[3:0];
    endfunction

    // Most significant nonzero digit; an all-zero value still yields digit 0.
    function automatic logic [IW-1:0] msd(input logic [DATA_W-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (nib(v, i) != 4'd0) r = IW'(i);
        return r;
    endfunction

    assign idx_dn = idx - IW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            data  <= '0;
            idx   <= '0;
            str   <= {N{8'h30}};
            chd   <= 8'h00;
            chv   <= 1'b0;
            chl   <= 1'b0;
        end else begin
            state <= state_n;
            data  <= data_n;
            idx   <= idx_n;
            str   <= str_n;
            chd   <= chd_n;
            chv   <= chv_n;
            chl   <= chl_n;
        end
    end

    always_comb begin
        state_n = state;
        data_n  = data;
        idx_n   = idx;
        str_n   = str;
        chd_n   = chd;
        chv_n   = chv;
        chl_n   = chl;
        start   = SUPPRESS_LZ != 0 ? msd(bus.in_data) : IW'(N - 1);
        case (state)
            IDLE: if (bus.in_valid) begin
                data_n = bus.in_data;
                idx_n  = start;
                for (int i = 0; i < N; i++) str_n[8*i +: 8] = hex_char(nib(bus.in_data, i));
                chv_n = 1'b1;
`ifdef HEX_PREFIX_EN
                chd_n   = 8'h30;
                chl_n   = 1'b0;
                state_n = PRE0;
`else
                chd_n   = hex_char(nib(bus.in_data, int'(start)));
                chl_n   = start == '0;
                state_n = SEND;
`endif
            end
`ifdef HEX_PREFIX_EN
            PRE0: if (bus.ch_ready) begin
                chd_n   = 8'h78;
                state_n = PREX;
            end
            PREX: if (bus.ch_ready) begin
                chd_n   = hex_char(nib(data, int'(idx)));
                chl_n   = idx == '0;
                state_n = SEND;
            end
`endif
            SEND: if (bus.ch_ready) begin
                if (chl) begin
                    chv_n   = 1'b0;
                    chl_n   = 1'b0;
                    state_n = IDLE;
                end else begin
                    idx_n = idx_dn;
                    chd_n = hex_char(nib(data, int'(idx_dn)));
                    chl_n = idx_dn == '0;
                end
            end
        endcase
    end

    assign bus.in_ready = state == IDLE;
    assign bus.busy     = state != IDLE;
    assign bus.str_out  = str;
    assign bus.ch_data  = chd;
    assign bus.ch_valid = chv;
    assign bus.ch_last  = chl;
endmodule

// File: tb/tb_hex_ascii_streamer.sv
// tb_hex_ascii_streamer: scoreboard bench over three builds (default, leading-zero
// suppression, lower case); expected characters are queued per vector, a monitor checks them.
module tb_hex_ascii_streamer;
`ifdef HEX_PREFIX_EN
    localparam int PFX = 2;
`else
    localparam int PFX = 0;
`endif

    logic clk, rst;
    int vectors = 0, miscompares = 0;
    logic [16:0] sb[$];
    bit       stall[3];
    bit       pl[3];
    logic [7:0] pd[3];

    hex_ascii_streamer_if #(.DATA_W(32)) b0();
    hex_ascii_streamer_if #(.DATA_W(32)) b1();
    hex_ascii_streamer_if #(.DATA_W(32)) b2();

    hex_ascii_streamer #(.DATA_W(32), .UPPER_CASE(1), .SUPPRESS_LZ(0)) d0 (.clk(clk), .rst(rst), .bus(b0));
    hex_ascii_streamer #(.DATA_W(32), .UPPER_CASE(1), .SUPPRESS_LZ(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
    hex_ascii_streamer #(.DATA_W(32), .UPPER_CASE(0), .SUPPRESS_LZ(0)) d2 (.clk(clk), .rst(rst), .bus(b2));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_str(input int k, input string s);
`ifdef HEX_PREFIX_EN
        sb.push_back({k[7:0], 8'h30, 1'b0});
        sb.push_back({k[7:0], 8'h78, 1'b0});
`endif
        for (int i = 0; i < s.len(); i++) sb.push_back({k[7:0], s[i], i == s.len() - 1});
    endtask

    task automatic mon(input int k, input logic v, input logic r, input logic l, input logic [7:0] d);
        logic [16:0] e;
        if (stall[k]) chk($sformatf("hold_dut%0d", k), {v, d, l}, {1'b1, pd[k], pl[k]});
        stall[k] = v && !r;
        pd[k] = d;
        pl[k] = l;
        if (v && r) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL extra_char_dut%0d: got %h expected none", k, d);
            end else begin
                e = sb.pop_front();
                chk($sformatf("char_dut%0d", k), {k[7:0], d, l}, e);
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) stall[i] = 0;
        end else begin
            mon(0, b0.ch_valid, b0.ch_ready, b0.ch_last, b0.ch_data);
            mon(1, b1.ch_valid, b1.ch_ready, b1.ch_last, b1.ch_data);
            mon(2, b2.ch_valid, b2.ch_ready, b2.ch_last, b2.ch_data);
        end
    end

    task automatic send(input int k, input logic [31:0] v);
        @(posedge clk); #1;
        case (k)
            0: begin b0.in_data = v; b0.in_valid = 1; end
            1: begin b1.in_data = v; b1.in_valid = 1; end
            default: begin b2.in_data = v; b2.in_valid = 1; end
        endcase
        @(posedge clk); #1;
        b0.in_valid = 0;
        b1.in_valid = 0;
        b2.in_valid = 0;
    endtask

    function automatic logic busy_of(input int k);
        return k == 0 ? b0.busy : k == 1 ? b1.busy : b2.busy;
    endfunction

    task automatic wait_done(input int k);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy_of(k)) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL done_timeout_dut%0d: got %0d pending expected 0", k, sb.size());
    endtask

    initial begin
        int n;
        rst = 1;
        b0.in_valid = 0; b1.in_valid = 0; b2.in_valid = 0;
        b0.in_data = '0; b1.in_data = '0; b2.in_data = '0;
        b0.ch_ready = 1; b1.ch_ready = 1; b2.ch_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("rst_str0", b0.str_out, 64'h3030303030303030);
        chk("rst_str1", b1.str_out, 64'h3030303030303030);
        chk("rst_str2", b2.str_out, 64'h3030303030303030);
        chk("rst_flags", {b0.in_ready, b0.ch_valid, b0.busy, b0.ch_last, b0.ch_data},
            {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});

        // straight stream, no backpressure
        expect_str(0, "AB01EF89");
        send(0, 32'hAB01EF89);
        chk("str_ab01ef89", b0.str_out, 64'h4142303145463839);
        n = 0;
        repeat (30) begin
            @(negedge clk);
            n++;
            if (b0.ch_valid && b0.ch_last) break;
        end
        chk("first_to_last_cycles", n, PFX + 8);
        @(negedge clk);
        chk("in_ready_after_last", b0.in_ready, 1'b1);
        wait_done(0);

        // backpressure plus an ignored in_valid pulse during SEND
        expect_str(0, "12345678");
        send(0, 32'h12345678);
        fork
            begin
                for (int i = 0; i < 45; i++) begin
                    b0.ch_ready = (i % 3 == 0);
                    @(posedge clk); #1;
                end
                b0.ch_ready = 1;
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("in_ready_busy", b0.in_ready, 1'b0);
                b0.in_data = 32'h99990000;
                b0.in_valid = 1;
                @(posedge clk); #1;
                b0.in_valid = 0;
            end
        join
        wait_done(0);
        chk("str_12345678_kept", b0.str_out, 64'h3132333435363738);

        // leading-zero suppression
        expect_str(1, "F0");
        send(1, 32'h000000F0);
        wait_done(1);
        chk("str_000000f0", b1.str_out, 64'h3030303030304630);
        expect_str(1, "0");
        send(1, 32'h00000000);
        wait_done(1);
        chk("str_zero", b1.str_out, 64'h3030303030303030);

        // lower case
        expect_str(2, "deadbeef");
        send(2, 32'hDEADBEEF);
        wait_done(2);
        chk("str_deadbeef", b2.str_out, 64'h6465616462656566);

        // asynchronous reset mid-stream
        expect_str(0, "AB01EF89");
        send(0, 32'hAB01EF89);
        repeat (3) @(posedge clk);
        #3 rst = 1;
        #1;
        chk("async_rst_valid", {b0.ch_valid, b0.ch_last, b0.busy, b0.in_ready}, 4'b0001);
        chk("async_rst_str", b0.str_out, 64'h3030303030303030);
        sb.delete();
        @(posedge clk); #1 rst = 0;
        expect_str(0, "0000000C");
        send(0, 32'h0000000C);
        chk("str_0000000c", b0.str_out, 64'h3030303030303043);
        wait_done(0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
